// File: rtl/shift8_capture_pkg.sv
// Shared types and sizing helpers for the shift8 capture slice.
// Stage count here must track the register depth of the upstream shift stage.
package shift8_pkg;

  typedef logic [1:0] sel_t;
  typedef logic [7:0] byte_t;

  localparam int SHIFT8_STAGES = 3;

  // Occupancy counter needs to hold DEPTH itself, hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/shift8_capture_if.sv
// Ready/valid byte stream leaving the capture block toward the next stage.
// master drives data/valid and samples ready; slave is the consumer.
interface shift8_capture_if;
  import shift8_pkg::*;

  byte_t out_data;
  logic  out_valid;
  logic  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/shift8_capture_fifo.sv
// Circular-buffer FIFO with explicit occupancy; head byte is registered storage, no bypass.
// Caller gates push on full/pop and pop on head_vld; simultaneous push+pop is legal when full.
module capture_fifo
  import shift8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  byte_t                         push_dat,
  input  logic                          pop,
  output byte_t                         head_dat,
  output logic                          head_vld,
  output logic [cnt_width(DEPTH)-1:0]   cnt,
  output logic                          full
);

  localparam int CW = cnt_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  byte_t           mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  // Storage is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_dat = mem[rptr];
  assign head_vld = (cnt != '0);
  assign full     = (cnt == CW'(DEPTH));

endmodule

// File: rtl/shift8_capture.sv
// Qualifies tapped bytes by replaying the shift-stage delay on in_valid, queues them, flags drops.
// Optional drop statistics under SHIFT8_CAPTURE_STATS_EN; otherwise drop_cnt reads 0.
module shift8_capture
  import shift8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  sel_t                          sel,
  input  logic                          in_valid,
  input  byte_t                         tap_data,
  shift8_capture_if.master              out_if,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output byte_t                         drop_cnt
);

  logic [SHIFT8_STAGES-1:0] vpipe;
  sel_t                     sel_q;
  logic                     sel_chg;
  logic                     tap_vld;
  logic                     full;
  logic                     head_vld;
  logic                     push;
  logic                     pop;
  logic                     drop;

  assign sel_chg = (sel != sel_q);

  // A tap change makes everything already in the shift stage belong to the old tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      sel_q <= '0;
    end else begin
      sel_q <= sel;
      vpipe <= sel_chg ? '0 : {vpipe[SHIFT8_STAGES-2:0], in_valid};
    end
  end

  always_comb begin
    tap_vld = 1'b0;
    if (!sel_chg) begin
      case (sel)
        2'd0:    tap_vld = in_valid;
        2'd1:    tap_vld = vpipe[0];
        2'd2:    tap_vld = vpipe[1];
        default: tap_vld = vpipe[2];
      endcase
    end
  end

  assign pop  = head_vld & out_if.out_ready;
  assign push = tap_vld & (~full | pop);
  assign drop = tap_vld & full & ~pop;

  capture_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (tap_data),
    .pop      (pop),
    .head_dat (out_if.out_data),
    .head_vld (head_vld),
    .cnt      (count),
    .full     (full)
  );

  assign out_if.out_valid = head_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef SHIFT8_CAPTURE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_shift8_capture.sv
// Directed bench for shift8_capture: latency per tap, overflow, full push+pop, tap change, async reset.
module tb_shift8_capture;
  import shift8_pkg::*;

`ifdef SHIFT8_CAPTURE_STATS_EN
  localparam logic [7:0] EXP_DROP = 8'd2;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  logic        clk;
  logic        rst_n;
  sel_t        sel;
  logic        in_valid;
  byte_t       tap_data;
  logic [2:0]  count;
  logic        overflow;
  byte_t       drop_cnt;

  int checks = 0;
  int fails  = 0;

  shift8_capture_if out_if ();

  shift8_capture #(
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .in_valid (in_valid),
    .tap_data (tap_data),
    .out_if   (out_if),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    byte_t exp_q [4];
    rst_n    = 1'b0;
    sel      = 2'd0;
    in_valid = 1'b0;
    tap_data = 8'h00;
    out_if.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_if.out_valid), 32'd0);
    chk("rst_count",     32'(count),            32'd0);
    chk("rst_overflow",  32'(overflow),         32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),         32'd0);
    rst_n = 1'b1;
    out_if.out_ready = 1'b1;

    // sel=0: each byte visible one edge after push, popped while the next arrives
    in_valid = 1'b1; tap_data = 8'h11; tick();
    chk("s0_b1_data", 32'(out_if.out_data), 32'h11);
    chk("s0_b1_cnt",  32'(count), 32'd1);
    tap_data = 8'h22; tick();
    chk("s0_b2_data", 32'(out_if.out_data), 32'h22);
    chk("s0_b2_cnt",  32'(count), 32'd1);
    tap_data = 8'h33; tick();
    chk("s0_b3_data", 32'(out_if.out_data), 32'h33);
    chk("s0_b3_vld",  32'(out_if.out_valid), 32'd1);
    chk("s0_b3_cnt",  32'(count), 32'd1);
    in_valid = 1'b0; tick();
    chk("s0_drain_vld", 32'(out_if.out_valid), 32'd0);
    chk("s0_drain_cnt", 32'(count), 32'd0);

    // sel=3: single in_valid, tap byte arrives three cycles later
    sel = 2'd3; tap_data = 8'h00; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("s3_c1_vld", 32'(out_if.out_valid), 32'd0);
    tick();
    chk("s3_c2_vld", 32'(out_if.out_valid), 32'd0);
    tick();
    chk("s3_c3_vld", 32'(out_if.out_valid), 32'd0);
    tap_data = 8'hA5; tick();
    chk("s3_c4_vld",  32'(out_if.out_valid), 32'd1);
    chk("s3_c4_data", 32'(out_if.out_data), 32'hA5);
    tap_data = 8'h00; tick();
    chk("s3_pop_vld", 32'(out_if.out_valid), 32'd0);

    // sel=1, no consumer: six bytes, four stored, two dropped
    out_if.out_ready = 1'b0;
    sel = 2'd1; tick();
    for (int i = 0; i <= 6; i++) begin
      in_valid = (i < 6);
      tap_data = byte_t'(i);
      tick();
      if (i == 4) begin
        chk("ov_full_cnt", 32'(count), 32'd4);
        chk("ov_pre_flag", 32'(overflow), 32'd0);
      end
    end
    chk("ov_cnt",      32'(count), 32'd4);
    chk("ov_head",     32'(out_if.out_data), 32'h01);
    chk("ov_flag",     32'(overflow), 32'd1);
    chk("ov_drop_cnt", 32'(drop_cnt), 32'(EXP_DROP));

    // full FIFO: push 0x77 while popping 0x01
    in_valid = 1'b1; tap_data = 8'h00; tick();
    chk("fp_hold_cnt", 32'(count), 32'd4);
    in_valid = 1'b0; out_if.out_ready = 1'b1; tap_data = 8'h77; tick();
    chk("fp_cnt",      32'(count), 32'd4);
    chk("fp_head",     32'(out_if.out_data), 32'h02);
    chk("fp_flag",     32'(overflow), 32'd1);
    chk("fp_drop_cnt", 32'(drop_cnt), 32'(EXP_DROP));
    tap_data = 8'h00;
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h77};
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("fp_drain_data", 32'(out_if.out_data), 32'(exp_q[k]));
    end
    tick();
    chk("fp_empty_vld", 32'(out_if.out_valid), 32'd0);
    chk("fp_empty_cnt", 32'(count), 32'd0);

    // asynchronous reset in the middle of a burst with three bytes queued
    out_if.out_ready = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      in_valid = 1'b1;
      tap_data = byte_t'(8'h10 + i);
      tick();
    end
    chk("ar_pre_cnt", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld",      32'(out_if.out_valid), 32'd0);
    chk("ar_cnt",      32'(count), 32'd0);
    chk("ar_flag",     32'(overflow), 32'd0);
    chk("ar_drop_cnt", 32'(drop_cnt), 32'd0);
    sel = 2'd0; in_valid = 1'b0;
    #1 rst_n = 1'b1;
    in_valid = 1'b1; tap_data = 8'h5A; out_if.out_ready = 1'b1; tick();
    chk("ar_first_vld",  32'(out_if.out_valid), 32'd1);
    chk("ar_first_data", 32'(out_if.out_data), 32'h5A);
    chk("ar_first_cnt",  32'(count), 32'd1);
    in_valid = 1'b0; tick();
    chk("ar_drain_cnt", 32'(count), 32'd0);

    // tap change 2->0 with two valid bytes in flight
    sel = 2'd2; tick();
    in_valid = 1'b1; tick();
    tick();
    chk("tc_pre_vld", 32'(out_if.out_valid), 32'd0);
    sel = 2'd0; tap_data = 8'hEE; tick();
    chk("tc_chg_vld",  32'(out_if.out_valid), 32'd0);
    chk("tc_chg_cnt",  32'(count), 32'd0);
    chk("tc_chg_flag", 32'(overflow), 32'd0);
    tap_data = 8'h99; tick();
    chk("tc_new_vld",  32'(out_if.out_valid), 32'd1);
    chk("tc_new_data", 32'(out_if.out_data), 32'h99);
    chk("tc_new_cnt",  32'(count), 32'd1);
    in_valid = 1'b0; tick();
    chk("tc_drain_cnt", 32'(count), 32'd0);
    chk("tc_end_flag",  32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
